// File: rtl/bsg_pkg.sv
// Shared types and helpers for the unary bitstream generator.
// Holds the IDLE/RUN state enum and a width-parameterised bit-reverse function.
package bsg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BSG_MAX_W = 32;

  // Mirrors the low w bits of v; bits at or above w come back as zero.
  function automatic logic [BSG_MAX_W-1:0] bit_rev(input logic [BSG_MAX_W-1:0] v,
                                                   input int w);
    logic [BSG_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BSG_MAX_W; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitstream_ref_cnt.sv
// Period counter for the bitstream generator: counts 0..2^IWID-1 while running,
// flags the last cycle, and produces the comparison reference (bit-reversed when BSG_BITREV_EN is defined).
module bitstream_ref_cnt
  import bsg_pkg::*;
#(
  parameter int IWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            clear,
  output logic [IWID-1:0] cnt,
  output logic [IWID-1:0] ref_val,
  output logic            last
);

  // Outside RUN the counter parks at zero so every new period starts at cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = run && (cnt == {IWID{1'b1}});

`ifdef BSG_BITREV_EN
  // Bit reversal is a permutation of 0..2^IWID-1, so per-period one counts are unchanged.
  assign ref_val = IWID'(bit_rev(BSG_MAX_W'(cnt), IWID));
`else
  assign ref_val = cnt;
`endif

endmodule

// File: rtl/bitstream_gen_double.sv
// Double-buffered unary rate-coded bitstream generator (active + shadow banks).
// Optional macro BSG_BITREV_EN selects a bit-reversed reference sequence.
module bitstream_gen_double
  import bsg_pkg::*;
#(
  parameter int ODIM = 4,
  parameter int IWID = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iValid,
  output logic                      oReady,
  input  logic [ODIM-1:0][IWID-1:0] iData,
  input  logic                      iClear,
  output logic                      oValid,
  output logic                      oLast,
  output logic [ODIM-1:0]           oData,
  output state_t                    dbg_state
);

  // Handshake: a value set is taken on any rising edge where iValid && oReady;
  // oReady depends only on registered state, never on iValid.

  state_t                    state, state_n;
  logic                      full, full_n;
  logic [ODIM-1:0][IWID-1:0] active, active_n;
  logic [ODIM-1:0][IWID-1:0] shadow, shadow_n;
  logic [IWID-1:0]           cnt;
  logic [IWID-1:0]           ref_val;
  logic                      last;
  logic                      accept;

  bitstream_ref_cnt #(
    .IWID(IWID)
  ) u_ref_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state == RUN),
    .clear  (iClear),
    .cnt    (cnt),
    .ref_val(ref_val),
    .last   (last)
  );

  assign oReady    = (state == IDLE) || !full;
  assign accept    = iValid && oReady;
  assign oValid    = (state == RUN);
  assign oLast     = last;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      full   <= 1'b0;
      active <= '0;
      shadow <= '0;
    end else begin
      state  <= state_n;
      full   <= full_n;
      active <= active_n;
      shadow <= shadow_n;
    end
  end

  always_comb begin
    state_n  = state;
    full_n   = full;
    active_n = active;
    shadow_n = shadow;
    if (iClear) begin
      // Flush wins over any same-cycle load or swap.
      state_n  = IDLE;
      full_n   = 1'b0;
      active_n = '0;
      shadow_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            active_n = iData;
            state_n  = RUN;
          end
        end
        RUN: begin
          if (last) begin
            // Period boundary: swap in shadow, else bypass a fresh load, else stop.
            if (full) begin
              active_n = shadow;
              full_n   = 1'b0;
            end else if (accept) begin
              active_n = iData;
            end else begin
              state_n = IDLE;
            end
          end else if (accept) begin
            shadow_n = iData;
            full_n   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ODIM; i++) begin : g_stream
    assign oData[i] = oValid && (active[i] > ref_val);
  end

endmodule

// File: tb/tb_bitstream_gen_double.sv
// Bench for bitstream_gen_double (IWID=4, ODIM=2): directed scenarios plus random traffic
// against a period/position reference model and per-period one-count checks.
module tb_bitstream_gen_double;
  import bsg_pkg::*;

  localparam int ODIM = 2;
  localparam int IWID = 4;
  localparam int PER  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      iValid = 1'b0;
  logic                      iClear = 1'b0;
  logic [ODIM-1:0][IWID-1:0] iData = '0;
  logic                      oReady, oValid, oLast;
  logic [ODIM-1:0]           oData;
  state_t                    dbg_state;

  bitstream_gen_double #(
    .ODIM(ODIM),
    .IWID(IWID)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iValid   (iValid),
    .oReady   (oReady),
    .iData    (iData),
    .iClear   (iClear),
    .oValid   (oValid),
    .oLast    (oLast),
    .oData    (oData),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: running flag, position in period, current value set, pending sets
  bit             m_run = 1'b0;
  int             m_pos = 0;
  int             m_cur[ODIM];
  logic [7:0]     exp_q[$];
  int             ones[ODIM];

  function automatic int ref_of(input int p);
`ifdef BSG_BITREV_EN
    int r, x;
    r = 0;
    x = p;
    for (int k = 0; k < IWID; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
`else
    return p;
`endif
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    exp_q.delete();
    for (int i = 0; i < ODIM; i++) m_cur[i] = 0;
  endtask

  task automatic check_outputs();
    logic [ODIM-1:0] ed;
    for (int i = 0; i < ODIM; i++) ed[i] = m_run && (m_cur[i] > ref_of(m_pos));
    check("oValid", 32'(oValid), 32'(m_run));
    check("oLast", 32'(oLast), 32'(m_run && m_pos == PER - 1));
    check("oReady", 32'(oReady), 32'(!m_run || exp_q.size() == 0));
    check("oData", 32'(oData), 32'(ed));
    check("state", 32'(dbg_state == RUN), 32'(m_run));
    if (m_run) begin
      if (m_pos == 0) for (int i = 0; i < ODIM; i++) ones[i] = 0;
      for (int i = 0; i < ODIM; i++) ones[i] += int'(oData[i]);
      if (m_pos == PER - 1) begin
        check("ones0", 32'(ones[0]), 32'(m_cur[0]));
        check("ones1", 32'(ones[1]), 32'(m_cur[1]));
      end
    end
  endtask

  // driver: called at a falling edge; checks, drives, advances one clock
  task automatic step(input bit v, input bit clr, input int d0, input int d1);
    bit acc;
    logic [7:0] s;
    check_outputs();
    iValid  = v;
    iClear  = clr;
    iData[0] = d0[3:0];
    iData[1] = d1[3:0];
    acc = v && (!m_run || exp_q.size() == 0);
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (!m_run) begin
      if (acc) begin
        m_cur[0] = d0;
        m_cur[1] = d1;
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos != PER - 1) begin
      if (acc) exp_q.push_back({d1[3:0], d0[3:0]});
      m_pos++;
    end else begin
      m_pos = 0;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        m_cur[0] = int'(s[3:0]);
        m_cur[1] = int'(s[7:4]);
      end else if (acc) begin
        m_cur[0] = d0;
        m_cur[1] = d1;
      end else begin
        m_run = 1'b0;
      end
    end
    @(negedge clk);
    iValid = 1'b0;
    iClear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_oValid", 32'(oValid), 32'd0);
    check("rst_oLast", 32'(oLast), 32'd0);
    check("rst_oData", 32'(oData), 32'd0);
    check("rst_oReady", 32'(oReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    for (int i = 0; i < ODIM; i++) ones[i] = 0;
    repeat (2) @(negedge clk);
    check("init_oValid", 32'(oValid), 32'd0);
    check("init_oReady", 32'(oReady), 32'd1);
    check("init_oData", 32'(oData), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single load, then drain back to IDLE
    step(1'b1, 1'b0, 5, 0);
    idle(18);
    check("idle_after_period", 32'(dbg_state == RUN), 32'd0);

    // shadow load mid-period, gapless swap
    step(1'b1, 1'b0, 3, 15);
    idle(4);
    step(1'b1, 1'b0, 12, 1);
    step(1'b1, 1'b0, 9, 9);
    idle(34);

    // bypass load exactly on the last cycle
    step(1'b1, 1'b0, 7, 7);
    n = 0;
    while (!(m_run && m_pos == PER - 1) && n < 40) begin
      idle(1);
      n++;
    end
    check("bypass_reached_last", 32'(m_run && m_pos == PER - 1), 32'd1);
    step(1'b1, 1'b0, 2, 14);
    check("bypass_oValid", 32'(oValid), 32'd1);
    idle(20);

    // clear with a simultaneous load, then restart
    step(1'b1, 1'b0, 10, 6);
    idle(6);
    step(1'b1, 1'b1, 4, 4);
    idle(2);
    step(1'b1, 1'b0, 2, 3);
    idle(18);

    // async reset mid-period
    step(1'b1, 1'b0, 11, 13);
    idle(9);
    reset_pulse();
    idle(3);
    step(1'b1, 1'b0, 8, 4);
    idle(34);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_gen_double.md
BITSTREAM_GEN_DOUBLE -- requirements
Module: bitstream_gen_double

Interface
REQ-001 Parameter ODIM, default 4, number of parallel output bitstreams.
REQ-002 Parameter IWID, default 8, width of each binary input value; bitstream period is 2^IWID cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iValid  input  1  iData holds a new value set.
REQ-006 oReady  output  1  block accepts iData this cycle; a load is accepted when iValid & oReady.
REQ-007 iData  input  [IWID-1:0] x ODIM  unsigned binary values, one per stream.
REQ-008 iClear  input  1  synchronous flush.
REQ-009 oValid  output  1  oData carries a live bitstream.
REQ-010 oLast  output  1  last cycle of the current period.
REQ-011 oData  output  [0:0] x ODIM  unary rate-coded bitstreams.

Function
REQ-012 Two banks SHALL exist: an active bank, which drives generation, and a shadow bank, which holds the next value set; a flag full marks a valid shadow.
REQ-013 A period counter cnt, IWID bits wide, SHALL increment by 1 each RUN cycle and wrap from 2^IWID-1 to 0.
REQ-014 oData[i] SHALL be (active[i] > ref) when oValid=1 and 0 otherwise; ref = cnt.
REQ-015 Over one period, the number of ones on stream i SHALL equal active[i] exactly; value 0 gives all zeros, and value 2^IWID-1 gives one zero.
REQ-016 The state machine has two states, IDLE and RUN; oValid=1 only in RUN.
REQ-017 IDLE: oReady=1; an accepted load SHALL write active, set cnt=0, and enter RUN, so the first bit appears the next cycle.
REQ-018 RUN: oReady = ~full; an accepted load SHALL write shadow and set full.
REQ-019 oLast SHALL be 1 in RUN when cnt = 2^IWID-1.
REQ-020 At the oLast cycle with full=1, the block SHALL copy shadow to active, clear full, and stay in RUN with no gap cycle.
REQ-021 At the oLast cycle with full=0 and an accepted load, the block SHALL write the load directly into active and stay in RUN (bypass).
REQ-022 At the oLast cycle with full=0 and no load, the block SHALL enter IDLE.
REQ-023 iClear SHALL take priority over any load or swap: next state IDLE, full=0, cnt=0, banks zeroed, and the same-cycle load is dropped.
REQ-024 oData, oValid and oLast are combinational from registered state only; no input-to-output combinational path is permitted.

Reset
REQ-025 rst_n low SHALL force state=IDLE, cnt=0, full=0 and both banks=0, giving outputs oValid=0, oLast=0, oData=0, oReady=1.
REQ-026 Reset asserted mid-period SHALL abort the period immediately; no stale bits appear after release.

Configuration
REQ-027 Macro BSG_BITREV_EN, when defined, SHALL make ref the bit-reversed cnt (a low-discrepancy sequence); when undefined, ref = cnt.
REQ-028 The exact one-count per period of REQ-015 SHALL hold in both builds.

Structure
REQ-029 A shared package bsg_pkg SHALL hold the state enum (IDLE, RUN) and a parameterised bit-reverse function.
REQ-030 A single sub-module bitstream_ref_cnt SHALL contain cnt, the wrap/oLast logic and the optional bit reversal; bitstream_gen_double instantiates it once.

Verification (IWID=4, ODIM=2, period 16)
REQ-031 Reset, then load {5,0} in IDLE -> oValid=1 next cycle; stream0 gives ones on cycles 0-4 of the period, stream1 stays all zero, oLast on cycle 15, then IDLE.
REQ-032 Load {3,15}, then load {12,1} mid-period -> oReady=0 until the swap; the second period follows with no gap and gives 12 and 1 ones.
REQ-033 Load {7,7} only, with a second iValid asserted exactly on the oLast cycle -> bypass: the period after shows the new value, oValid stays 1.
REQ-034 iClear at cycle 6 together with iValid -> next cycle IDLE, oData=0, load dropped; a later load restarts with cnt=0.
REQ-035 rst_n pulsed low at cycle 9 of the period -> all outputs 0 at once; after release oReady=1 and oValid=0.
REQ-036 Build with BSG_BITREV_EN, load {8,4} -> stream0 is 1 on even cycles (1010...), stream1 is 1 on cycles 0,4,8,12; each period gives 8 and 4 ones.
